// File: rtl/byte_striping_tx.sv
// Purpose : serial-to-4-lane byte striper; consecutive bytes go round-robin to lanes 0..3,
//           each completed (or flushed) group is presented in parallel with a one-cycle valid pulse.
// Latency : valid_out asserts the cycle after the byte that completes or closes the group.
// Backpressure: none; accepts one byte every cycle, full rate gives one group every 4 cycles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   valid_in, data_in     serial byte input, qualified by valid_in
//   flush                 close the pending partial group, unused lanes padded with PAD
//   data_out0..3          lane buses (lane 0 = first byte of group), hold between pulses
//   valid_out             one-cycle pulse when the lane buses carry a new group
//   lane_mask             bit k set when lane k carries real data rather than PAD
//   busy                  a partial group is pending
//   lane_parity           (only with BYTE_STRIPING_TX_PARITY_EN) XOR reduction of each lane bus
//
// Optional feature macro: BYTE_STRIPING_TX_PARITY_EN
module byte_striping_tx #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PAD   = 8'hBC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic             valid_out,
  output logic [3:0]       lane_mask,
  output logic             busy
`ifdef BYTE_STRIPING_TX_PARITY_EN
  ,
  output logic [3:0]       lane_parity
`endif
);

  // One-hot: state LANEk means the next accepted byte lands on lane k.
  typedef enum logic [3:0] {
    LANE0 = 4'b0001,
    LANE1 = 4'b0010,
    LANE2 = 4'b0100,
    LANE3 = 4'b1000
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] stage [4];

  logic [1:0]       lane_idx;
  logic             emit;
  logic [2:0]       n_real;
  logic [3:0]       real_lane;
  logic [WIDTH-1:0] grp [4];

  always_comb begin
    case (state)
      LANE1:   lane_idx = 2'd1;
      LANE2:   lane_idx = 2'd2;
      LANE3:   lane_idx = 2'd3;
      default: lane_idx = 2'd0;
    endcase
  end

  // Decide whether a group leaves this cycle and how many lanes are real.
  // A byte arriving together with flush is accepted first, so it counts as real.
  always_comb begin
    emit   = 1'b0;
    n_real = 3'd0;
    if (valid_in) begin
      if (lane_idx == 2'd3) begin
        emit   = 1'b1;
        n_real = 3'd4;
      end else if (flush) begin
        emit   = 1'b1;
        n_real = {1'b0, lane_idx} + 3'd1;
      end
    end else if (flush && lane_idx != 2'd0) begin
      emit   = 1'b1;
      n_real = {1'b0, lane_idx};
    end
  end

  // Outgoing lane contents: the in-flight byte bypasses staging for its own lane.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      real_lane[j] = (3'(j) < n_real);
      if (valid_in && (2'(j) == lane_idx)) begin
        grp[j] = data_in;
      end else if (real_lane[j]) begin
        grp[j] = stage[j];
      end else begin
        grp[j] = PAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LANE0;
      for (int i = 0; i < 4; i++) stage[i] <= '0;
      data_out0 <= '0;
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
      valid_out <= 1'b0;
      lane_mask <= 4'b0000;
`ifdef BYTE_STRIPING_TX_PARITY_EN
      lane_parity <= 4'b0000;
`endif
    end else begin
      valid_out <= emit;
      if (valid_in) begin
        stage[lane_idx] <= data_in;
      end
      if (emit) begin
        state     <= LANE0;
        data_out0 <= grp[0];
        data_out1 <= grp[1];
        data_out2 <= grp[2];
        data_out3 <= grp[3];
        lane_mask <= real_lane;
`ifdef BYTE_STRIPING_TX_PARITY_EN
        lane_parity <= {^grp[3], ^grp[2], ^grp[1], ^grp[0]};
`endif
      end else if (valid_in) begin
        // Rotate the one-hot token to the next lane.
        state <= state_t'({state[2:0], state[3]});
      end
    end
  end

  assign busy = (state != LANE0);

endmodule

// File: tb/tb_byte_striping_tx.sv
module tb_byte_striping_tx;

  localparam logic [7:0] PADV = 8'hBC;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       flush;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out;
  logic [3:0] lane_mask;
  logic       busy;
`ifdef BYTE_STRIPING_TX_PARITY_EN
  logic [3:0] lane_parity;
`endif

  byte_striping_tx #(.WIDTH(8), .PAD(PADV)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .flush     (flush),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .valid_out (valid_out),
    .lane_mask (lane_mask),
    .busy      (busy)
`ifdef BYTE_STRIPING_TX_PARITY_EN
    ,
    .lane_parity (lane_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the bytes of the pending group, plus the last group presented.
  logic [7:0] pend [$];
  logic [7:0] exp_lane [4];
  logic [3:0] exp_mask;
  logic       exp_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus, model update, and checks of every output after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic f);
    logic [7:0] got [4];
    @(negedge clk);
    reset    = r;
    valid_in = v;
    data_in  = d;
    flush    = f;
    exp_vld  = 1'b0;
    if (r) begin
      pend.delete();
      for (int k = 0; k < 4; k++) exp_lane[k] = 8'h00;
      exp_mask = 4'b0000;
    end else begin
      if (v) pend.push_back(d);
      if (pend.size() == 4 || (f && pend.size() > 0)) begin
        for (int k = 0; k < 4; k++) begin
          exp_lane[k] = (k < pend.size()) ? pend[k] : PADV;
          exp_mask[k] = (k < pend.size());
        end
        exp_vld = 1'b1;
        pend.delete();
      end
    end
    @(posedge clk);
    #1;
    got[0] = data_out0;
    got[1] = data_out1;
    got[2] = data_out2;
    got[3] = data_out3;
    check("valid_out", 32'(valid_out), 32'(exp_vld));
    check("busy", 32'(busy), 32'(pend.size() != 0));
    check("lane_mask", 32'(lane_mask), 32'(exp_mask));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("data_out%0d", k), 32'(got[k]), 32'(exp_lane[k]));
`ifdef BYTE_STRIPING_TX_PARITY_EN
      check($sformatf("lane_parity%0d", k), 32'(lane_parity[k]), 32'(^exp_lane[k]));
`endif
    end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    flush    = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Single full group.
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);

    // Two back-to-back groups.
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(2);

    // Partial group closed by a lone flush.
    send(8'hA0); send(8'hA1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Flush together with a byte, mid-group and on the 4th byte.
    send(8'hC0);
    step(1'b0, 1'b1, 8'hC1, 1'b1);
    idle(1);
    send(8'hD0); send(8'hD1); send(8'hD2);
    step(1'b0, 1'b1, 8'hD3, 1'b1);
    idle(2);

    // Gaps between bytes, then flush while idle in lane 0.
    send(8'h10); idle(3);
    send(8'h20); send(8'h30); idle(1);
    send(8'h40);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // Flush with a byte in lane 0 yields a one-lane group.
    step(1'b0, 1'b1, 8'hE7, 1'b1);
    idle(1);

    // Reset mid-group discards staged bytes.
    send(8'hF1); send(8'hF2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
